avalon_pio_edge: RTL and testbench
==================================

AVALON_PIO_EDGE -- requirements
Module: avalon_pio_edge

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the port width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the reset value of the output data register (WIDTH bits).
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, selecting the captured edge: 0 rising, 1 falling, 2 any.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is posedge clk.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port address, input, 3 bits: word register select.
REQ-007 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data; bits above WIDTH-1 are ignored.
REQ-010 The block SHALL have port readdata, output, 32 bits: read data; bits above WIDTH-1 read 0.
REQ-011 The block SHALL have port in_port, input, WIDTH bits: asynchronous pin inputs.
REQ-012 The block SHALL have port out_port, output, WIDTH bits: registered output data.
REQ-013 The block SHALL have port oe, output, WIDTH bits: per-bit output enable, equal to the direction register.
REQ-014 The block SHALL have port irq, output, 1 bit: level interrupt, active high.

Function
REQ-015 A write SHALL occur on a clk edge with chipselect=1 and write_n=0; reads SHALL be combinational from address (zero wait, zero read latency).
REQ-016 Address 0 (DATA) SHALL read bit i as data_out[i] when dir[i]=1, otherwise as the synchronised input sync[i]; a write SHALL load data_out.
REQ-017 Address 1 (DIR) SHALL be read/write; 1 = output.
REQ-018 Address 2 (IRQMASK) SHALL be read/write; 1 = edge bit enabled onto irq.
REQ-019 Address 3 (EDGECAP) SHALL read the capture register; writing 1 to a bit SHALL clear it, writing 0 SHALL leave it unchanged.
REQ-020 Address 4 (OUTSET) SHALL set data_out bits written as 1; address 5 (OUTCLR) SHALL clear data_out bits written as 1; both SHALL read 0.
REQ-021 Addresses 6 and 7 SHALL read 0 and ignore writes.
REQ-022 in_port SHALL pass through a two-flop synchroniser (sync) and one further history stage (prev); edge detection SHALL compare sync with prev.
REQ-023 A detected edge SHALL set its EDGECAP bit on the clk edge following the one that updates sync with the new level (three clk edges after a setup-valid in_port change), for input-direction bits and output-direction bits alike.
REQ-024 When a new edge and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win.
REQ-025 irq SHALL be registered and equal OR over (EDGECAP & IRQMASK), updating one clk after either changes.
REQ-026 out_port SHALL equal data_out directly; an OUTSET/OUTCLR/DATA write SHALL appear on out_port one clk after the write edge.

Reset
REQ-027 On reset_n=0, data_out SHALL become RESET_VALUE; DIR, IRQMASK, EDGECAP, sync, prev and irq SHALL become 0, immediately and independently of clk.
REQ-028 Reset asserted mid-write SHALL abort the write; the synchroniser reset to 0 SHALL NOT cause a spurious edge after release (first comparison uses reset values on both stages).

Configuration
REQ-029 With macro AVALON_PIO_EDGE_IRQ_EN defined, edge capture, IRQMASK and irq SHALL be implemented as specified.
REQ-030 Without AVALON_PIO_EDGE_IRQ_EN, addresses 2 and 3 SHALL read 0 and ignore writes, irq SHALL be tied 0, and no edge or mask flops SHALL be synthesised.

Structure
REQ-031 A shared package avalon_pio_pkg SHALL hold the register address constants (ADDR_DATA..ADDR_OUTCLR) and EDGE_TYPE encodings.
REQ-032 The synchroniser plus edge detector SHALL be one sub-module, pio_edge_detect, parameterised by WIDTH and EDGE_TYPE.

Verification
REQ-033 Reset release with RESET_VALUE=16'hA5A5 -> out_port=16'hA5A5, oe=0, irq=0, all register reads 0 except DATA (reads sync=0).
REQ-034 Write DATA=16'h00F0, OUTSET=16'h0003, OUTCLR=16'h0010 -> out_port 16'h00E3 after the last write.
REQ-035 DIR=16'h00FF, in_port=16'hAB00, data_out=16'h0012 -> DATA reads 16'hAB12 after sync delay.
REQ-036 EDGE_TYPE=0, IRQMASK=1, in_port[0] 0->1 -> EDGECAP=1, irq=1; write EDGECAP=1 -> irq=0 next cycle; falling edge causes no capture.
REQ-037 New rising edge on bit 2 in the same cycle as EDGECAP clear write of 4 -> EDGECAP bit 2 remains 1.
REQ-038 Build without AVALON_PIO_EDGE_IRQ_EN, toggle in_port -> irq stays 0, addresses 2/3 read 0.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// Shared register map and edge-type encodings for the Avalon PIO with edge capture.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_edge_detect.sv
// Two-flop input synchroniser plus history stage and edge detector.
// The history stage and edge output exist only with AVALON_PIO_EDGE_IRQ_EN defined.
module pio_edge_detect
  import avalon_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
`ifdef AVALON_PIO_EDGE_IRQ_EN
  output logic [WIDTH-1:0] edge_det,
`endif
  output logic [WIDTH-1:0] sync
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // p0/p1: metastability synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  assign sync = sync_p1;

`ifdef AVALON_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] prev_p2;

  // p2: history of the synchronised level; both stages reset to 0 so release is edge-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_p2 <= '0;
    end else begin
      prev_p2 <= sync_p1;
    end
  end

  if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign edge_det = prev_p2 & ~sync_p1;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign edge_det = prev_p2 ^ sync_p1;
  end else begin : g_rise
    assign edge_det = sync_p1 & ~prev_p2;
  end
`else
  localparam int unsigned UNUSED_EDGE_TYPE = EDGE_TYPE;
`endif

endmodule

// File: rtl/avalon_pio_edge.sv
// Avalon-MM parallel I/O port with direction control and optional edge capture/IRQ.
// Edge capture, IRQMASK and irq are built only with AVALON_PIO_EDGE_IRQ_EN defined.
module avalon_pio_edge
  import avalon_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rd_val;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

`ifdef AVALON_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
`endif

  pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
`ifdef AVALON_PIO_EDGE_IRQ_EN
    .edge_det (edge_det),
`endif
    .sync     (sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data_out <= wdata;
        ADDR_DIR:    dir      <= wdata;
        ADDR_OUTSET: data_out <= data_out | wdata;
        ADDR_OUTCLR: data_out <= data_out & ~wdata;
        default:     ;
      endcase
    end
  end

  assign out_port = data_out;
  assign oe       = dir;

`ifdef AVALON_PIO_EDGE_IRQ_EN
  assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

  // Set is ORed in after the clear so a simultaneous edge survives a write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) begin
        irq_mask <= wdata;
      end
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
      irq      <= |(edge_cap & irq_mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:    rd_val = (data_out & dir) | (sync & ~dir);
      ADDR_DIR:     rd_val = dir;
`ifdef AVALON_PIO_EDGE_IRQ_EN
      ADDR_IRQMASK: rd_val = irq_mask;
      ADDR_EDGECAP: rd_val = edge_cap;
`endif
      default:      rd_val = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

endmodule

// File: tb/tb_avalon_pio_edge.sv
// Scoreboard bench for avalon_pio_edge; covers both builds of AVALON_PIO_EDGE_IRQ_EN.
`timescale 1ns/1ps
module tb_avalon_pio_edge;
  import avalon_pio_pkg::*;

  localparam int W     = 16;
  localparam int K_RD  = 0;
  localparam int K_OUT = 1;
  localparam int K_OE  = 2;
  localparam int K_IRQ = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic [W-1:0]  out_port;
  logic [W-1:0]  oe;
  logic          irq;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  avalon_pio_edge #(
    .WIDTH       (W),
    .RESET_VALUE (16'hA5A5),
    .EDGE_TYPE   (EDGE_RISE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always @(negedge clk) begin : monitor
    item_t       it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        K_RD:    act = readdata;
        K_OUT:   act = 32'(out_port);
        K_OE:    act = 32'(oe);
        default: act = {31'd0, irq};
      endcase
      n_vec++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %h, want %h", it.name, act, it.exp);
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    address = a;
    sb.push_back('{kind: K_RD, exp: e, name: nm});
  endtask

  task automatic expect_sig(input int k, input logic [31:0] e, input string nm);
    sb.push_back('{kind: k, exp: e, name: nm});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_vec++;
    if (out_port !== 16'hA5A5) begin
      n_err++;
      $display("FAIL direct_rst_out_port: got %h", out_port);
    end
    n_vec++;
    if (oe !== 16'h0000) begin
      n_err++;
      $display("FAIL direct_rst_oe: got %h", oe);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL direct_rst_irq: got %b", irq);
    end
    expect_sig(K_OUT, 32'h0000_A5A5, "rst_out_port");
    expect_sig(K_OE,  32'h0, "rst_oe");
    expect_sig(K_IRQ, 32'h0, "rst_irq");
    expect_rd(ADDR_DATA, 32'h0, "rst_rd_data");
    sample();
    for (int a = 1; a < 8; a++) begin
      expect_rd(3'(a), 32'h0, $sformatf("rst_rd_addr%0d", a));
      sample();
    end

    // DATA / OUTSET / OUTCLR
    wr(ADDR_DATA, 32'h0000_00F0);
    wr(ADDR_OUTSET, 32'h0000_0003);
    expect_sig(K_OUT, 32'h0000_00F3, "outset_out");
    sample();
    wr(ADDR_OUTCLR, 32'h0000_0010);
    n_vec++;
    if (out_port !== 16'h00E3) begin
      n_err++;
      $display("FAIL direct_outclr_out: got %h", out_port);
    end
    expect_sig(K_OUT, 32'h0000_00E3, "outclr_out");
    expect_rd(ADDR_OUTSET, 32'h0, "outset_reads0");
    sample();

    // Mixed direction read-back; upper writedata bits dropped
    wr(ADDR_DIR, 32'hFFFF_00FF);
    wr(ADDR_DATA, 32'h0000_0012);
    in_port = 16'hAB00;
    repeat (3) sample();
    expect_rd(ADDR_DATA, 32'h0000_AB12, "data_mixed_dir");
    expect_sig(K_OE, 32'h0000_00FF, "oe_dir");
    expect_sig(K_OUT, 32'h0000_0012, "data_out");
    sample();
    expect_rd(ADDR_DIR, 32'h0000_00FF, "dir_rd");
    sample();

    // Addresses 6/7 ignore writes
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    expect_rd(3'd6, 32'h0, "addr6_rd");
    expect_sig(K_OUT, 32'h0000_0012, "addr67_no_effect");
    sample();
    expect_rd(3'd7, 32'h0, "addr7_rd");
    sample();

    // Async reset with a write in flight
    in_port = '0;
    repeat (3) sample();
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    address    = ADDR_DATA;
    writedata  = 32'h0000_1234;
    chipselect = 1'b1;
    write_n    = 1'b0;
    expect_sig(K_OUT, 32'h0000_A5A5, "async_rst_out");
    expect_sig(K_OE, 32'h0, "async_rst_oe");
    sample();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b1;
    expect_sig(K_OUT, 32'h0000_A5A5, "abort_write_out");
    expect_rd(ADDR_DIR, 32'h0, "abort_dir");
    sample();

`ifdef AVALON_PIO_EDGE_IRQ_EN
    expect_rd(ADDR_EDGECAP, 32'h0, "no_spurious_edge");
    sample();
    wr(ADDR_IRQMASK, 32'h0000_0001);
    expect_rd(ADDR_IRQMASK, 32'h0000_0001, "irqmask_rd");
    sample();

    // Rising edge on bit 0: capture on the third edge, irq one later
    @(posedge clk);
    #1;
    in_port = 16'h0001;
    sample();
    sample();
    expect_rd(ADDR_EDGECAP, 32'h0, "cap_not_yet");
    sample();
    expect_rd(ADDR_EDGECAP, 32'h0000_0001, "cap_set");
    expect_sig(K_IRQ, 32'h0, "irq_lag");
    sample();
    expect_sig(K_IRQ, 32'h1, "irq_set");
    sample();
    wr(ADDR_EDGECAP, 32'h0000_0001);
    expect_rd(ADDR_EDGECAP, 32'h0, "cap_clr");
    expect_sig(K_IRQ, 32'h1, "irq_hold");
    sample();
    expect_sig(K_IRQ, 32'h0, "irq_clr");
    sample();

    // Falling edge is not captured for EDGE_RISE
    in_port = '0;
    repeat (4) sample();
    expect_rd(ADDR_EDGECAP, 32'h0, "fall_no_cap");
    expect_sig(K_IRQ, 32'h0, "fall_no_irq");
    sample();

    // Bit 2 captured but masked off
    in_port = 16'h0004;
    repeat (4) sample();
    expect_rd(ADDR_EDGECAP, 32'h0000_0004, "cap_bit2");
    expect_sig(K_IRQ, 32'h0, "irq_masked");
    sample();
    in_port = '0;
    repeat (4) sample();

    // New edge coincides with clear of the same bit: set wins
    @(posedge clk);
    #1;
    in_port = 16'h0004;
    repeat (3) sample();
    wr(ADDR_EDGECAP, 32'h0000_0004);
    expect_rd(ADDR_EDGECAP, 32'h0000_0004, "set_wins_clr");
    sample();
    wr(ADDR_EDGECAP, 32'h0000_0004);
    expect_rd(ADDR_EDGECAP, 32'h0, "clr_bit2");
    sample();
`else
    wr(ADDR_IRQMASK, 32'h0000_FFFF);
    wr(ADDR_EDGECAP, 32'h0000_FFFF);
    in_port = 16'hFFFF;
    repeat (4) sample();
    in_port = '0;
    repeat (4) sample();
    expect_rd(ADDR_IRQMASK, 32'h0, "noirq_mask_rd");
    expect_sig(K_IRQ, 32'h0, "noirq_irq0");
    sample();
    expect_rd(ADDR_EDGECAP, 32'h0, "noirq_cap_rd");
    sample();
    in_port = 16'h5555;
    repeat (4) sample();
    expect_sig(K_IRQ, 32'h0, "noirq_irq1");
    expect_rd(ADDR_DATA, 32'h0000_5555, "noirq_data_in");
    sample();
`endif

    repeat (2) sample();
    if (n_vec < 12) begin
      n_err++;
      $display("FAIL too few vectors: %0d", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err != 0) begin
      $display("FAIL");
      $fatal(1);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
